rr_arbiter_8: RTL and testbench

Round-robin arbiter that shares one decoded resource between eight requesters. Each cycle it picks a winner in rotating priority order, registers the winner as a 3-bit index, and expands it through the 3-to-8 decode into a one-hot grant. The grant is locked until the owner drops its request. The block sits in front of the 3-to-8 decoded select path and is the only driver of its select inputs.

---
 rtl/rr_arbiter_8.sv | 107 ++++++++++
 tb/tb_rr_arbiter_8.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - eight-way round-robin arbiter with locked grant and decoded select; optional RR_ARB_TIMEOUT_EN hold limit
module rr_arbiter_8 #(
  parameter int HOLD_MAX = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] req,
  output logic       grant_valid,
  output logic [2:0] grant_idx,
  output logic [7:0] grant_onehot,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [2:0] last_idx, last_nxt;
  logic [2:0] idx_nxt;
  logic [2:0] winner;
  logic       win_found;
  logic       timeout_nxt;
  logic       hold_limit;

  // Reject out-of-range hold limits at elaboration time
  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("rr_arbiter_8: HOLD_MAX out of range");
  end

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;

  // Count cycles spent in GRANT; any IDLE cycle rearms the counter at zero
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      hold_cnt <= 8'd0;
    end else if (state == GRANT) begin
      hold_cnt <= hold_cnt + 8'd1;
    end else begin
      hold_cnt <= 8'd0;
    end
  end

  assign hold_limit = (hold_cnt == 8'(HOLD_MAX - 1));
`else
  assign hold_limit = 1'b0;
`endif

  // Rotating-priority search starting one past the most recent winner
  always_comb begin
    logic [2:0] cand;
    winner    = 3'd0;
    win_found = 1'b0;
    cand      = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      cand = last_idx + 3'(k);
      if (!win_found && req[cand]) begin
        winner    = cand;
        win_found = 1'b1;
      end
    end
  end

  // Next-state logic: arbitrate only from IDLE, hold until release or revoke
  always_comb begin
    state_nxt   = state;
    idx_nxt     = grant_idx;
    last_nxt    = last_idx;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = GRANT;
          idx_nxt   = winner;
          last_nxt  = winner;
        end
      end
      GRANT: begin
        if (!req[grant_idx]) begin
          state_nxt = IDLE;
        end else if (hold_limit) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, owner index, priority pointer and revoke pulse registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      grant_idx <= 3'd0;
      last_idx  <= 3'd7;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant_idx <= idx_nxt;
      last_idx  <= last_nxt;
      timeout   <= timeout_nxt;
    end
  end

  assign grant_valid  = (state == GRANT);
  assign grant_onehot = grant_valid ? (8'd1 << grant_idx) : 8'h00;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - directed self-checking bench for rr_arbiter_8
module tb_rr_arbiter_8;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic [7:0] grant_onehot;
  logic       timeout;

  int tests = 0;
  int failed = 0;

  rr_arbiter_8 #(.HOLD_MAX(4)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .req          (req),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot),
    .timeout      (timeout)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    req = 8'h00;
    step();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step();
      tests++;
      if ({grant_valid, grant_idx, grant_onehot, timeout} !== 13'd0) begin
        failed++;
        $display("FAIL reset_idle cyc=%0d got v=%b idx=%0d oh=%h to=%b want all zero",
                 c, grant_valid, grant_idx, grant_onehot, timeout);
      end
    end
  endtask

  task automatic test_single_hold();
    do_reset();
    req = 8'h08;
    for (int c = 0; c < 3; c++) begin
      step();
      tests++;
      if ({grant_valid, grant_idx, grant_onehot} !== {1'b1, 3'd3, 8'h08}) begin
        failed++;
        $display("FAIL single_hold cyc=%0d got v=%b idx=%0d oh=%h want v=1 idx=3 oh=08",
                 c, grant_valid, grant_idx, grant_onehot);
      end
    end
    req = 8'h00;
    step();
    tests++;
    if ({grant_valid, grant_onehot} !== {1'b0, 8'h00}) begin
      failed++;
      $display("FAIL single_release got v=%b oh=%h want v=0 oh=00", grant_valid, grant_onehot);
    end
  endtask

  task automatic test_rotate();
    logic [2:0] exp;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      exp = 3'(k % 8);
      req = 8'hFF;
      step();
      tests++;
      if ({grant_valid, grant_idx, grant_onehot} !== {1'b1, exp, 8'(1 << exp)}) begin
        failed++;
        $display("FAIL rotate k=%0d got v=%b idx=%0d oh=%h want v=1 idx=%0d",
                 k, grant_valid, grant_idx, grant_onehot, exp);
      end
      req = 8'hFF & ~(8'd1 << exp);
      step();
      tests++;
      if (grant_valid !== 1'b0) begin
        failed++;
        $display("FAIL rotate_gap k=%0d got v=%b want v=0", k, grant_valid);
      end
    end
  endtask

  task automatic test_lock();
    do_reset();
    req = 8'h04;
    step();
    tests++;
    if ({grant_valid, grant_idx} !== {1'b1, 3'd2}) begin
      failed++;
      $display("FAIL lock_first got v=%b idx=%0d want v=1 idx=2", grant_valid, grant_idx);
    end
    req = 8'h24;
    for (int c = 0; c < 3; c++) begin
      step();
      tests++;
      if ({grant_valid, grant_idx} !== {1'b1, 3'd2}) begin
        failed++;
        $display("FAIL lock_hold cyc=%0d got v=%b idx=%0d want v=1 idx=2", c, grant_valid, grant_idx);
      end
    end
    req = 8'h20;
    step();
    tests++;
    if (grant_valid !== 1'b0) begin
      failed++;
      $display("FAIL lock_release got v=%b want v=0", grant_valid);
    end
    step();
    tests++;
    if ({grant_valid, grant_idx, grant_onehot} !== {1'b1, 3'd5, 8'h20}) begin
      failed++;
      $display("FAIL lock_next got v=%b idx=%0d oh=%h want v=1 idx=5 oh=20",
               grant_valid, grant_idx, grant_onehot);
    end
  endtask

  task automatic test_wrap_single();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      req = 8'h80;
      step();
      tests++;
      if ({grant_valid, grant_idx, grant_onehot} !== {1'b1, 3'd7, 8'h80}) begin
        failed++;
        $display("FAIL wrap_single k=%0d got v=%b idx=%0d oh=%h want v=1 idx=7 oh=80",
                 k, grant_valid, grant_idx, grant_onehot);
      end
      req = 8'h00;
      step();
    end
    req = 8'h81;
    step();
    tests++;
    if (grant_idx !== 3'd0) begin
      failed++;
      $display("FAIL wrap_to_zero got idx=%0d want idx=0", grant_idx);
    end
  endtask

  task automatic test_reset_in_grant();
    do_reset();
    req = 8'h40;
    step();
    tests++;
    if ({grant_valid, grant_idx} !== {1'b1, 3'd6}) begin
      failed++;
      $display("FAIL rst_grant_pre got v=%b idx=%0d want v=1 idx=6", grant_valid, grant_idx);
    end
    sys_rst = 1'b1;
    req = 8'h41;
    step();
    tests++;
    if ({grant_valid, grant_idx, grant_onehot, timeout} !== 13'd0) begin
      failed++;
      $display("FAIL rst_grant_drop got v=%b idx=%0d oh=%h to=%b want all zero",
               grant_valid, grant_idx, grant_onehot, timeout);
    end
    sys_rst = 1'b0;
    step();
    tests++;
    if ({grant_valid, grant_idx} !== {1'b1, 3'd0}) begin
      failed++;
      $display("FAIL rst_grant_next got v=%b idx=%0d want v=1 idx=0", grant_valid, grant_idx);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 8'h03;
`ifdef RR_ARB_TIMEOUT_EN
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        tests++;
        if ({grant_valid, grant_idx, timeout} !== {1'b1, 3'(r % 2), 1'b0}) begin
          failed++;
          $display("FAIL timeout_hold r=%0d c=%0d got v=%b idx=%0d to=%b want v=1 idx=%0d to=0",
                   r, c, grant_valid, grant_idx, timeout, r % 2);
        end
      end
      step();
      tests++;
      if ({grant_valid, timeout} !== 2'b01) begin
        failed++;
        $display("FAIL timeout_pulse r=%0d got v=%b to=%b want v=0 to=1", r, grant_valid, timeout);
      end
    end
`else
    for (int c = 0; c < 40; c++) begin
      step();
      tests++;
      if ({grant_valid, grant_idx, timeout} !== {1'b1, 3'd0, 1'b0}) begin
        failed++;
        $display("FAIL no_timeout c=%0d got v=%b idx=%0d to=%b want v=1 idx=0 to=0",
                 c, grant_valid, grant_idx, timeout);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_hold();
    test_rotate();
    test_lock();
    test_wrap_single();
    test_reset_in_grant();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
